fir_scheduler: RTL

Job scheduler in front of the FIR filter controller. Accepts sample-ready and coefficient-reload requests from the bus-side register block, arbitrates them at job boundaries, and drives the controller's dr/lc handshake, including the four-step coefficient load sequence with coeff_sel steering. Reports completion, controller errors, handshake timeouts and sample overruns back to the status register.

---
 rtl/fir_sched_pkg.sv | 23 ++
 rtl/fir_sched_if.sv | 38 +++
 rtl/flex_counter.sv | 39 +++
 rtl/fir_scheduler.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/fir_sched_pkg.sv
// fir_sched_pkg
//   Shared types and constants for the FIR job scheduler: FSM state
//   encoding, coefficient count and index width, and a small helper
//   used to qualify the handshake watchdog.
package fir_sched_pkg;

  localparam int COEFF_COUNT = 4;
  localparam int COEFF_IDX_W = 2;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ISSUE_DR  = 3'd1,
    WAIT_DATA = 3'd2,
    ISSUE_LC  = 3'd3,
    WAIT_LC   = 3'd4
  } sched_state_t;

  // The watchdog only runs in the two states that wait for modwait to rise.
  function automatic logic is_issue(input sched_state_t s);
    return (s == ISSUE_DR) || (s == ISSUE_LC);
  endfunction

endpackage

// File: rtl/fir_sched_if.sv
// fir_sched_if
//   Groups the scheduler's register-block side (requests, status) and
//   controller side (dr/lc handshake, coeff_sel) into one bundle.
//   master : the scheduler itself
//   slave  : the surrounding register block / FIR controller
interface fir_sched_if;
  import fir_sched_pkg::*;

  // register-block side
  logic                   sample_req;
  logic                   coeff_req;
  logic                   status_clr;
  logic                   busy;
  logic                   coeff_loaded;
  logic                   result_valid;
  logic                   err_pulse;
  logic                   overrun;
  logic                   timeout;
  // controller side
  logic                   modwait;
  logic                   ctrl_err;
  logic                   dr;
  logic                   lc;
  logic [COEFF_IDX_W-1:0] coeff_sel;

  modport master (
    input  sample_req, coeff_req, status_clr, modwait, ctrl_err,
    output dr, lc, coeff_sel, busy, coeff_loaded, result_valid,
           err_pulse, overrun, timeout
  );

  modport slave (
    output sample_req, coeff_req, status_clr, modwait, ctrl_err,
    input  dr, lc, coeff_sel, busy, coeff_loaded, result_valid,
           err_pulse, overrun, timeout
  );

endinterface

// File: rtl/flex_counter.sv
// flex_counter
//   Modulo-N up-counter used as the handshake watchdog. Counts 0..N-1 and
//   wraps; o_rollover_flag marks the enabled cycle in which the wrap
//   happens, i.e. it is high after exactly N enabled cycles since clear.
// Ports:
//   clk, n_rst        clock, async active-low reset
//   i_clear           synchronous clear to 0 (wins over count)
//   i_count_enable    advance the count this cycle
//   i_rollover_val    modulus N (N >= 1)
//   o_rollover_flag   N-th enabled cycle since clear
module flex_counter #(
  parameter int NUM_CNT_BITS = 4
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic                    i_clear,
  input  logic                    i_count_enable,
  input  logic [NUM_CNT_BITS-1:0] i_rollover_val,
  output logic                    o_rollover_flag
);

  logic [NUM_CNT_BITS-1:0] r_count;
  logic                    w_at_top;

  assign w_at_top = (r_count == (i_rollover_val - 1'b1));

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_count_enable) begin
      r_count <= w_at_top ? '0 : r_count + 1'b1;
    end
  end

  assign o_rollover_flag = i_count_enable & ~i_clear & w_at_top;

endmodule

// File: rtl/fir_scheduler.sv
// fir_scheduler
//   Job scheduler in front of the FIR filter controller. Latches sample and
//   coefficient-reload requests, starts one job at a time from IDLE
//   (coefficients first), drives the dr/lc handshake with coeff_sel
//   steering, and reports completion, controller error, overrun and
//   handshake timeout.
// Ports:
//   clk, n_rst   clock, async active-low reset
//   bus          fir_sched_if.master (requests/status + controller handshake)
//
// state     | meaning
// ----------+-------------------------------------------------------------
// IDLE      | no job; pick coef_pend, else samp_pend
// ISSUE_DR  | dr high, waiting for controller to raise modwait
// WAIT_DATA | controller filtering; leave when modwait drops
// ISSUE_LC  | lc high with coeff_sel=idx, waiting for modwait
// WAIT_LC   | coefficient stored; next idx or finish the set
module fir_scheduler
  import fir_sched_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 8,
  parameter int TO_BITS        = 4
) (
  input logic         clk,
  input logic         n_rst,
  fir_sched_if.master bus
);

  sched_state_t           r_state;
  logic                   r_samp_pend;
  logic                   r_coef_pend;
  logic                   r_dr;
  logic                   r_lc;
  logic [COEFF_IDX_W-1:0] r_coeff_sel;
  logic                   r_busy;
  logic                   r_coeff_loaded;
  logic                   r_result_valid;
  logic                   r_err_pulse;
  logic                   r_overrun;
  logic                   r_timeout;

  logic w_coef_any;
  logic w_samp_any;
  logic w_coef_take;
  logic w_samp_take;
  logic w_overrun_set;
  logic w_wd_clear;
  logic w_wd_count;
  logic w_wd_expire;
  logic w_last_coeff;

  // A request arriving in IDLE is acted on in the same cycle, so the
  // pending flag and the live pulse are both considered.
  assign w_coef_any    = r_coef_pend | bus.coeff_req;
  assign w_samp_any    = r_samp_pend | bus.sample_req;
  assign w_coef_take   = (r_state == IDLE) & w_coef_any;
  assign w_samp_take   = (r_state == IDLE) & ~w_coef_any & w_samp_any;
  assign w_overrun_set = bus.sample_req & r_samp_pend & ~w_samp_take;
  assign w_last_coeff  = (r_coeff_sel == COEFF_IDX_W'(COEFF_COUNT - 1));

  // Held clear outside the ISSUE states, so each ISSUE entry starts at 0.
  assign w_wd_clear = ~is_issue(r_state);
  assign w_wd_count = is_issue(r_state) & ~bus.modwait;

  flex_counter #(
    .NUM_CNT_BITS (TO_BITS)
  ) u_watchdog (
    .clk             (clk),
    .n_rst           (n_rst),
    .i_clear         (w_wd_clear),
    .i_count_enable  (w_wd_count),
    .i_rollover_val  (TO_BITS'(TIMEOUT_CYCLES)),
    .o_rollover_flag (w_wd_expire)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state        <= IDLE;
      r_samp_pend    <= 1'b0;
      r_coef_pend    <= 1'b0;
      r_dr           <= 1'b0;
      r_lc           <= 1'b0;
      r_coeff_sel    <= '0;
      r_busy         <= 1'b0;
      r_coeff_loaded <= 1'b0;
      r_result_valid <= 1'b0;
      r_err_pulse    <= 1'b0;
      r_overrun      <= 1'b0;
      r_timeout      <= 1'b0;
    end else begin
      r_result_valid <= 1'b0;
      r_err_pulse    <= 1'b0;

      // When a flag is consumed, a request in the same cycle becomes the
      // next pending one only if the flag was already set; otherwise the
      // live pulse itself is what got consumed.
      r_samp_pend <= w_samp_take ? (r_samp_pend & bus.sample_req)
                                 : (r_samp_pend | bus.sample_req);
      r_coef_pend <= w_coef_take ? (r_coef_pend & bus.coeff_req)
                                 : (r_coef_pend | bus.coeff_req);

      if (w_overrun_set)       r_overrun <= 1'b1;
      else if (bus.status_clr) r_overrun <= 1'b0;

      if (w_wd_expire)         r_timeout <= 1'b1;
      else if (bus.status_clr) r_timeout <= 1'b0;

      if (bus.coeff_req) r_coeff_loaded <= 1'b0;

      unique case (r_state)
        IDLE: begin
          if (w_coef_any) begin
            r_state     <= ISSUE_LC;
            r_coeff_sel <= '0;
            r_lc        <= 1'b1;
            r_busy      <= 1'b1;
          end else if (w_samp_any) begin
            r_state <= ISSUE_DR;
            r_dr    <= 1'b1;
            r_busy  <= 1'b1;
          end
        end

        ISSUE_DR: begin
          if (bus.modwait) begin
            r_state <= WAIT_DATA;
            r_dr    <= 1'b0;
          end else if (w_wd_expire) begin
            r_state <= IDLE;
            r_dr    <= 1'b0;
            r_busy  <= 1'b0;
          end
        end

        WAIT_DATA: begin
          if (!bus.modwait) begin
            if (bus.ctrl_err) r_err_pulse    <= 1'b1;
            else              r_result_valid <= 1'b1;
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        end

        ISSUE_LC: begin
          if (bus.modwait) begin
            r_state <= WAIT_LC;
            r_lc    <= 1'b0;
          end else if (w_wd_expire) begin
            r_state <= IDLE;
            r_lc    <= 1'b0;
            r_busy  <= 1'b0;
          end
        end

        WAIT_LC: begin
          if (!bus.modwait) begin
            if (w_last_coeff) begin
              r_state <= IDLE;
              r_busy  <= 1'b0;
              // A reload requested mid-sequence makes this set stale.
              if (!r_coef_pend && !bus.coeff_req) r_coeff_loaded <= 1'b1;
            end else begin
              r_state     <= ISSUE_LC;
              r_coeff_sel <= r_coeff_sel + 1'b1;
              r_lc        <= 1'b1;
            end
          end
        end

        default: begin
          r_state <= IDLE;
          r_dr    <= 1'b0;
          r_lc    <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.dr           = r_dr;
  assign bus.lc           = r_lc;
  assign bus.coeff_sel    = r_coeff_sel;
  assign bus.busy         = r_busy;
  assign bus.coeff_loaded = r_coeff_loaded;
  assign bus.result_valid = r_result_valid;
  assign bus.err_pulse    = r_err_pulse;
  assign bus.overrun      = r_overrun;
  assign bus.timeout      = r_timeout;

endmodule
